// File: rtl/mac_channel_scheduler_if.sv
// Request/grant and MAC-control bundle between the channel front ends,
// the scheduler and the shared coefficient-indexed MAC.
interface mac_channel_scheduler_if #(
    parameter int NCH = 4,
    parameter int CHW = 2
);
    logic [NCH-1:0] req;
    logic           halt;
    logic [NCH-1:0] ack;
    logic [CHW-1:0] ch_sel;
    logic [3:0]     coeff_sel;
    logic           sum_rst;
    logic           sum_en;
    logic           srdyo;
    logic [CHW-1:0] out_ch;
    logic           busy;

    modport master (
        output req, halt,
        input  ack, ch_sel, coeff_sel, sum_rst, sum_en, srdyo, out_ch, busy
    );

    modport slave (
        input  req, halt,
        output ack, ch_sel, coeff_sel, sum_rst, sum_en, srdyo, out_ch, busy
    );
endinterface

// File: rtl/mac_channel_scheduler.sv
// Round-robin scheduler sharing one MAC datapath across NCH channels: grant,
// clear accumulator, step TAPS coefficients, then flag the result.
module mac_channel_scheduler #(
    parameter int NCH  = 4,
    parameter int CHW  = 2,
    parameter int TAPS = 11
) (
    input logic                    clk,
    input logic                    GlobalReset,
    mac_channel_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;

    localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);

    state_t         r_state,   w_state;
    logic [CHW-1:0] r_ptr,     w_ptr;
    logic [NCH-1:0] r_ack,     w_ack;
    logic [CHW-1:0] r_ch_sel,  w_ch_sel;
    logic [3:0]     r_coeff,   w_coeff;
    logic           r_sum_rst, w_sum_rst;
    logic           r_sum_en,  w_sum_en;
    logic           r_srdyo,   w_srdyo;
    logic [CHW-1:0] r_out_ch,  w_out_ch;
    logic           r_busy,    w_busy;

    logic [CHW-1:0] w_win;
    logic           w_found;

    // Rotating priority search: first set request at or above r_ptr, wrapping.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_found && bus.req[r_ptr + CHW'(i)]) begin
                w_win   = r_ptr + CHW'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_ack     = '0;
        w_ch_sel  = r_ch_sel;
        w_coeff   = '0;
        w_sum_rst = 1'b0;
        w_sum_en  = 1'b0;
        w_srdyo   = 1'b0;
        w_out_ch  = r_out_ch;
        unique case (r_state)
            IDLE: begin
                if (!bus.halt && w_found) begin
                    w_state   = CLEAR;
                    w_ch_sel  = w_win;
                    w_ack     = NCH'(1) << w_win;
                    w_ptr     = w_win + CHW'(1);
                    w_sum_rst = 1'b1;
                end
            end
            CLEAR: begin
                w_state  = ACCUM;
                w_sum_en = 1'b1;
            end
            ACCUM: begin
                if (r_coeff == LAST_TAP) begin
                    w_state  = DONE;
                    w_srdyo  = 1'b1;
                    w_out_ch = r_ch_sel;
                end else begin
                    w_sum_en = 1'b1;
                    w_coeff  = r_coeff + 4'd1;
                end
            end
            DONE: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign w_busy = (w_state != IDLE);

    // Every output is a register loaded with its next-cycle value.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_ack     <= '0;
            r_ch_sel  <= '0;
            r_coeff   <= '0;
            r_sum_rst <= 1'b0;
            r_sum_en  <= 1'b0;
            r_srdyo   <= 1'b0;
            r_out_ch  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_ack     <= w_ack;
            r_ch_sel  <= w_ch_sel;
            r_coeff   <= w_coeff;
            r_sum_rst <= w_sum_rst;
            r_sum_en  <= w_sum_en;
            r_srdyo   <= w_srdyo;
            r_out_ch  <= w_out_ch;
            r_busy    <= w_busy;
        end
    end

    assign bus.ack       = r_ack;
    assign bus.ch_sel    = r_ch_sel;
    assign bus.coeff_sel = r_coeff;
    assign bus.sum_rst   = r_sum_rst;
    assign bus.sum_en    = r_sum_en;
    assign bus.srdyo     = r_srdyo;
    assign bus.out_ch    = r_out_ch;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mac_channel_scheduler.sv
// Scoreboard bench for mac_channel_scheduler: directed grant scenarios push
// expected acks/results; a negedge monitor pops and checks them.
module tb_mac_channel_scheduler;
    localparam int NCH  = 4;
    localparam int CHW  = 2;
    localparam int TAPS = 11;

    typedef struct {
        int ch;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic GlobalReset;
    int   total = 0;
    int   bad   = 0;
    exp_t q_ack[$];
    int   q_rdy[$];

    mac_channel_scheduler_if #(.NCH(NCH), .CHW(CHW)) bus ();

    mac_channel_scheduler #(.NCH(NCH), .CHW(CHW), .TAPS(TAPS)) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: phase counts cycles since the ack (CLEAR) cycle.
    int phase    = -1;
    int cyc      = 0;
    int last_ack = 0;
    always @(negedge clk) begin
        exp_t e;
        int   r;
        cyc++;
        if (GlobalReset) begin
            phase = -1;
        end else begin
            if (bus.ack != '0) begin
                phase = 0;
                if (q_ack.size() == 0) begin
                    chk("unexpected_ack", int'(bus.ack), 0);
                end else begin
                    e = q_ack.pop_front();
                    chk("ack_onehot", int'(bus.ack), 1 << e.ch);
                    chk("ch_sel", int'(bus.ch_sel), e.ch);
                    if (e.gap != 0) chk("ack_spacing", cyc - last_ack, e.gap);
                end
                last_ack = cyc;
                chk("sum_rst_with_ack", int'(bus.sum_rst), 1);
            end else if (phase >= 0) begin
                phase++;
            end
            if (phase >= 1 && phase <= TAPS) begin
                chk("sum_en", int'(bus.sum_en), 1);
                chk("coeff_sel", int'(bus.coeff_sel), phase - 1);
            end else begin
                chk("en_coeff_idle", int'({bus.sum_en, bus.coeff_sel}), 0);
            end
            chk("busy", int'(bus.busy), (phase >= 0) ? 1 : 0);
            chk("rst_en_excl", int'(bus.sum_rst & bus.sum_en), 0);
            chk("ack_srdyo_excl", int'((|bus.ack) & bus.srdyo), 0);
            if (bus.srdyo || phase == TAPS + 1) begin
                chk("srdyo", int'(bus.srdyo), 1);
                chk("srdyo_phase", phase, TAPS + 1);
                if (q_rdy.size() != 0) begin
                    r = q_rdy.pop_front();
                    chk("out_ch", int'(bus.out_ch), r);
                end else begin
                    chk("result_expected", q_rdy.size(), 1);
                end
                phase = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise req and service acks; sticky requesters keep their line high.
    task automatic serve(input logic [NCH-1:0] r, input bit sticky, input int n);
        int got = 0;
        int c   = 0;
        bus.req = r;
        while (got < n && c < 400) begin
            tick();
            c++;
            if (bus.ack != '0) begin
                got++;
                if (!sticky) bus.req = bus.req & ~bus.ack;
            end
            if (got == n) bus.req = '0;
        end
        chk("serve_grants", got, n);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q_ack.size() != 0 || q_rdy.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_in_budget", (n < budget) ? 1 : 0, 1);
    endtask

    task automatic expect_grant(input int ch, input int gap, input bit result);
        exp_t e;
        e.ch  = ch;
        e.gap = gap;
        q_ack.push_back(e);
        if (result) q_rdy.push_back(ch);
    endtask

    initial begin
        int n;
        GlobalReset = 1'b1;
        bus.req     = NCH'($urandom);
        bus.halt    = 1'b0;
        repeat (3) tick();
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_ch_sel", int'(bus.ch_sel), 0);
        chk("rst_coeff_sel", int'(bus.coeff_sel), 0);
        chk("rst_sum_rst", int'(bus.sum_rst), 0);
        chk("rst_sum_en", int'(bus.sum_en), 0);
        chk("rst_srdyo", int'(bus.srdyo), 0);
        chk("rst_out_ch", int'(bus.out_ch), 0);
        chk("rst_busy", int'(bus.busy), 0);
        bus.req = '0;
        tick();
        GlobalReset = 1'b0;
        tick();

        // Round robin from ptr=0 with every channel requesting.
        expect_grant(0, 0, 1);
        expect_grant(1, 14, 1);
        expect_grant(2, 14, 1);
        expect_grant(3, 14, 1);
        expect_grant(0, 14, 1);
        serve(4'b1111, 1'b1, 5);
        wait_idle(40);

        // Single request on channel 2 leaves ptr at 3.
        repeat (3) tick();
        expect_grant(2, 0, 1);
        serve(4'b0100, 1'b0, 1);
        wait_idle(40);

        // Wrap from ptr=3 skipping idle channels: ch0 then ch1.
        expect_grant(0, 0, 1);
        expect_grant(1, 14, 1);
        serve(4'b0011, 1'b0, 2);
        wait_idle(40);

        // halt in IDLE blocks grants.
        bus.halt = 1'b1;
        bus.req  = 4'b0001;
        n = 0;
        repeat (30) begin
            tick();
            if (bus.ack != '0) n++;
        end
        chk("halt_no_ack", n, 0);

        // Release halt, then raise it again mid-ACCUM: the sample still completes.
        expect_grant(0, 0, 1);
        bus.halt = 1'b0;
        serve(4'b0001, 1'b0, 1);
        repeat (5) tick();
        chk("halt_mid_accum_sum_en", int'(bus.sum_en), 1);
        bus.halt = 1'b1;
        wait_idle(40);
        bus.halt = 1'b0;

        // Abort ch1 at coeff_sel=5 with GlobalReset.
        expect_grant(1, 0, 0);
        serve(4'b0010, 1'b0, 1);
        n = 0;
        while (!(bus.sum_en && bus.coeff_sel == 4'd5) && n < 20) begin
            tick();
            n++;
        end
        chk("reached_coeff5", (n < 20) ? 1 : 0, 1);
        GlobalReset = 1'b1;
        #1;
        chk("abort_sum_en", int'(bus.sum_en), 0);
        chk("abort_coeff_sel", int'(bus.coeff_sel), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_ch_sel", int'(bus.ch_sel), 0);
        repeat (2) tick();
        GlobalReset = 1'b0;
        repeat (20) tick();

        // ptr returns to 0 after reset.
        expect_grant(0, 0, 1);
        serve(4'b1111, 1'b0, 1);
        wait_idle(40);

        chk("ack_queue_empty", q_ack.size(), 0);
        chk("rdy_queue_empty", q_rdy.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mac_channel_scheduler.md
# mac_channel_scheduler

Time-multiplexes the single coefficient-indexed multiply-accumulate datapath across NCH input channels. Channels raise per-channel sample-ready requests; the block grants one at a time in round-robin order, clears the accumulator, steps coeff_sel through all TAPS coefficients with sum_en held, then pulses srdyo with the channel number. It sits between the per-channel sample front ends and the shared MAC/coefficient ROM in the 32-channel filter path.

## Interface
Parameters:
- NCH, 4, number of requesting channels; power of two, 2..32
- CHW, 2, channel index width, equal to log2(NCH)
- TAPS, 11, coefficients per output sample; 1..16

Ports:
- clk  in  1  system clock, all logic on rising edge
- GlobalReset  in  1  reset GlobalReset, asynchronous, active-high; clock clk
- req  in  NCH  per-channel sample ready, level; requester holds high until its ack
- halt  in  1  when high, no new grant is issued; an operation in progress always completes
- ack  out  NCH  one-hot, one-cycle pulse: sample of that channel accepted
- ch_sel  out  CHW  channel currently owning the datapath (sample mux select)
- coeff_sel  out  4  coefficient index to ROM/MAC
- sum_rst  out  1  one-cycle accumulator clear
- sum_en  out  1  accumulate enable
- srdyo  out  1  one-cycle pulse: accumulated result valid
- out_ch  out  CHW  channel number of the result, valid while srdyo high
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, CLEAR, ACCUM, DONE. All outputs registered.
- IDLE: if halt=0 and req!=0, select winner = first set bit of req searching upward from ptr, wrapping at NCH-1 -> 0. Register ch_sel<=winner, ack<=one-hot(winner), ptr<=(winner+1) mod NCH, go CLEAR. Otherwise stay.
- CLEAR (1 cycle): ack pulse visible, sum_rst=1, sum_en=0, coeff_sel=0. Go ACCUM.
- ACCUM (TAPS cycles): sum_en=1, coeff_sel=0,1,...,TAPS-1, one value per cycle. After coeff_sel=TAPS-1 go DONE.
- DONE (1 cycle): sum_en=0, coeff_sel=0, srdyo=1, out_ch=ch_sel. Go IDLE.
- ch_sel holds the granted channel from CLEAR through DONE, and keeps its last value in IDLE.
- req changes during CLEAR/ACCUM/DONE are ignored. A req still high at the next IDLE is a new request. Requesters must drop req in the ack cycle.
- halt is sampled only in IDLE.
- Reset values: state=IDLE, ptr=0, ack=0, ch_sel=0, coeff_sel=0, sum_rst=0, sum_en=0, srdyo=0, out_ch=0, busy=0.
- GlobalReset asserted mid-operation aborts immediately to reset values. No srdyo is produced for the aborted sample. Operation resumes on the first clk edge after deassertion.

## Timing
- Grant decision in the IDLE cycle t. ack and sum_rst at t+1. sum_en with coeff_sel 0..TAPS-1 at t+2..t+1+TAPS. srdyo at t+2+TAPS.
- One sample occupies TAPS+3 cycles including IDLE. With TAPS=11, back-to-back grants are spaced 14 cycles apart.
- sum_rst and sum_en are never high in the same cycle. ack and srdyo are never high in the same cycle.
- Fairness: with all requests continuously high, each channel is granted exactly once per NCH grants.

## Test plan
- Reset: assert GlobalReset with random req. All outputs and ptr read their reset values; busy=0.
- Single request: req=4'b0100 at IDLE cycle t.
  - ack=4'b0100 and sum_rst=1 at t+1.
  - sum_en=1 with coeff_sel 0..10 at t+2..t+12.
  - srdyo=1 with out_ch=2 at t+13.
- Round robin: req=4'b1111 held.
  - Grant order is 0,1,2,3,0.
  - Consecutive acks are 14 cycles apart.
  - Each srdyo carries the matching out_ch.
- Wrap and skip: ptr=3 (after a grant to ch2), req=4'b0011. Grant goes to ch0, then ch1.
- halt:
  - halt=1 in IDLE with req=4'b0001: no ack for the whole halt period.
  - halt raised mid-ACCUM: the operation still completes with srdyo.
- Reset mid-operation: assert GlobalReset at coeff_sel=5 during ACCUM.
  - sum_en=0 and coeff_sel=0 immediately.
  - No srdyo.
  - Next grant with req=4'b1111 goes to ch0.
